// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : FSM state encoding (IDLE, ADJ, SHIFT, DONE)
//   min_digits : constant function giving the number of decimal digits
//                needed to hold 2^bin_w - 1 without overflow.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADJ   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned max_val;
    int unsigned     d;
    max_val = (64'd1 << bin_w) - 64'd1;
    d       = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (max_val != 0) begin
        d++;
        max_val = max_val / 64'd10;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_conv_digit_adj.sv
// Double-dabble digit correction: one BCD digit gets +3 when it is >= 5,
// so that the following left shift carries correctly into the next digit.
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : corrected digit
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), optional signed input.
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   start       : request a conversion (honoured only in IDLE)
//   signed_mode : treat bin_in as two's complement (sampled with start)
//   bin_in      : operand (sampled with start)
//   busy        : conversion in progress (ADJ, SHIFT, DONE)
//   done        : one-cycle pulse, results valid
//   bcd_out     : result digits, least significant digit in [3:0]
//   neg         : result is negative
//   overflow    : magnitude exceeds 10^DIGITS-1 (bcd_out saturated to all 9s)
module bin2bcd_seq_conv
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W     = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic               ovf_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic               in_neg;
  logic [BIN_W-1:0]   mag;

  // Most negative operand negates to itself, which read unsigned is
  // exactly the required magnitude 2^(BIN_W-1).
  always_comb begin
    in_neg = (SIGNED_EN != 0) && signed_mode && bin_in[BIN_W-1];
    mag    = in_neg ? ((~bin_in) + BIN_W'(1)) : bin_in;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (sr_q[BIN_W + 4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = ADJ;
      end
      ADJ:   state_d = SHIFT;
      SHIFT: state_d = (cnt_q == CNT_W'(1)) ? DONE : ADJ;
      DONE:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q   <= {{BCD_W{1'b0}}, mag};
            cnt_q  <= CNT_W'(BIN_W);
            sign_q <= in_neg;
            ovf_q  <= 1'b0;
          end
        end
        ADJ: sr_q <= {bcd_adj, sr_q[BIN_W-1:0]};
        SHIFT: begin
          // A 1 leaving the top digit means the decimal value no longer fits.
          if (sr_q[SR_W-1]) ovf_q <= 1'b1;
          sr_q  <= {sr_q[SR_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bcd_out  <= ovf_q ? {DIGITS{4'h9}} : sr_q[SR_W-1:BIN_W];
          neg      <= sign_q;
          overflow <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_conv.sv
// Self-checking bench for bin2bcd_seq_conv: default instance (16 bit, 5 digits)
// and a 4-digit instance for saturation. Expected values come from a decimal
// arithmetic model.
module tb_bin2bcd_seq_conv;

  localparam int LAT = 2 * 16 + 1;  // edges from start edge to done visible

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, signed_mode = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy, done, neg, overflow;
  logic [19:0] bcd_out;

  logic        start4 = 1'b0, signed_mode4 = 1'b0;
  logic [15:0] bin_in4 = '0;
  logic        busy4, done4, neg4, overflow4;
  logic [15:0] bcd_out4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_conv dut (
    .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .bin_in(bin_in), .busy(busy), .done(done), .bcd_out(bcd_out),
    .neg(neg), .overflow(overflow)
  );

  bin2bcd_seq_conv #(.DIGITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .signed_mode(signed_mode4),
    .bin_in(bin_in4), .busy(busy4), .done(done4), .bcd_out(bcd_out4),
    .neg(neg4), .overflow(overflow4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by /10 and %10.
  function automatic void model(input logic [15:0] v, input logic sm, input int digits,
                                output logic [39:0] bcd, output logic ng, output logic ov);
    longint unsigned mag, lim;
    ng  = sm && v[15];
    mag = ng ? (64'd65536 - 64'(v)) : 64'(v);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ov  = (mag > lim - 1);
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = ov ? 4'd9 : 4'(mag % 10);
      mag = mag / 10;
    end
  endfunction

  task automatic do_conv(input logic [15:0] v, input logic sm, input int inj_cycle,
                         input logic [15:0] inj_v, input string tag);
    logic [39:0] eb;
    logic        en, eo, busy_bad;
    logic [19:0] held;
    int          lat;
    model(v, sm, 5, eb, en, eo);
    @(negedge clk);
    start = 1'b1; bin_in = v; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; bin_in = 16'($urandom); signed_mode = 1'($urandom);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    lat = 0; busy_bad = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (inj_cycle != 0) begin
        if (lat == inj_cycle) begin
          start = 1'b1; bin_in = inj_v; signed_mode = ~sm;
        end else if (lat == inj_cycle + 1) begin
          start = 1'b0;
        end
      end
      if (!done && !busy) busy_bad = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_bcd"}, 64'(bcd_out), 64'(eb[19:0]));
    check({tag, "_neg"}, 64'(neg), 64'(en));
    check({tag, "_ovf"}, 64'(overflow), 64'(eo));
    check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    held = bcd_out;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(bcd_out), 64'(held));
  endtask

  task automatic do_conv4(input logic [15:0] v, input logic sm, input string tag);
    logic [39:0] eb;
    logic        en, eo;
    int          lat;
    model(v, sm, 4, eb, en, eo);
    @(negedge clk);
    start4 = 1'b1; bin_in4 = v; signed_mode4 = sm;
    @(posedge clk); #1;
    start4 = 1'b0; bin_in4 = 16'($urandom);
    lat = 0;
    while (!done4 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_bcd"}, 64'(bcd_out4), 64'(eb[15:0]));
    check({tag, "_neg"}, 64'(neg4), 64'(en));
    check({tag, "_ovf"}, 64'(overflow4), 64'(eo));
  endtask

  initial begin
    logic [15:0] rv;
    logic        rs;
    logic [15:0] ops [3];
    int          nd, t, last_t, done_seen;

    // Reset state
    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_neg", 64'(neg), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_bcd4", 64'(bcd_out4), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed operands
    do_conv(16'hFFFF, 1'b0, 0, '0, "u_ffff");
    check("u_ffff_lit", 64'(bcd_out), 64'h65535);
    do_conv(16'h8000, 1'b1, 0, '0, "s_8000");
    check("s_8000_lit", 64'(bcd_out), 64'h32768);
    do_conv(16'hFFFF, 1'b1, 0, '0, "s_ffff");
    do_conv(16'h0000, 1'b1, 0, '0, "s_zero");
    do_conv(16'h7FFF, 1'b1, 0, '0, "s_7fff");
    do_conv(16'h8000, 1'b0, 0, '0, "u_8000");

    // Start pulsed mid-conversion with a different operand
    do_conv(16'd1234, 1'b0, 10, 16'd4321, "mid_start");

    // Reset at cycle 10 of a conversion
    do_conv(16'd999, 1'b0, 0, '0, "pre_rst");
    @(negedge clk);
    start = 1'b1; bin_in = 16'd777; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_bcd", 64'(bcd_out), 64'd0);
    check("abort_neg_ovf", 64'({neg, overflow}), 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    reset_n = 1'b1;
    do_conv(16'd42, 1'b0, 0, '0, "post_rst");
    check("post_rst_lit", 64'(bcd_out), 64'h00042);

    // Back-to-back with start held high
    ops = '{16'd1, 16'd2, 16'd3};
    nd = 0; t = 0; last_t = 0;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; bin_in = ops[0];
    @(posedge clk); #1;
    while (nd < 3 && t < 300) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        check("b2b_bcd", 64'(bcd_out), 64'(ops[nd]));
        if (nd == 0) check("b2b_first_lat", 64'(t), 64'(LAT));
        else         check("b2b_spacing", 64'(t - last_t), 64'(LAT + 1));
        last_t = t;
        nd++;
        if (nd < 3) bin_in = ops[nd];
        else        start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(nd), 64'd3);

    // Four-digit instance: saturation boundary
    do_conv4(16'd12345, 1'b0, "d4_12345");
    check("d4_12345_lit", 64'({overflow4, bcd_out4}), 64'h19999);
    do_conv4(16'd9999, 1'b0, "d4_9999");
    check("d4_9999_lit", 64'({overflow4, bcd_out4}), 64'h09999);
    do_conv4(16'd10000, 1'b0, "d4_10000");
    do_conv4(16'hD8F0, 1'b1, "d4_neg10000");
    do_conv4(16'hD8F1, 1'b1, "d4_neg9999");

    // Randomized operands against the decimal model
    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom);
      rs = 1'($urandom);
      do_conv(rv, rs, 0, '0, "rand5");
    end
    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(0, 20000));
      rs = 1'($urandom);
      do_conv4(rv, rs, "rand4");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
